sum_last4_inv: RTL

- Inverse of the team's 4-tap moving-sum block. It takes the running sum of the last 4 samples and recovers the original 8-bit sample stream: in[n] = sum[n] - sum[n-1] + in[n-4].
- It sits on the receive side of any link that transports windowed sums. Initial conditions match the encoder: the previous sum and the last 4 recovered samples start at 0.
- Output is registered, with a valid strobe and a sticky consistency-error flag.

---
 rtl/sum_last4_inv.sv | 91 +++++++++
 1 files changed

// File: rtl/sum_last4_inv.sv
// Inverse 4-tap moving sum: recovers the sample stream from windowed sums,
// flagging any sum that cannot have come from a valid DW-bit source stream.
module sum_last4_inv #(
    parameter int unsigned DW = 8,
    parameter int unsigned SW = DW + 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          in_valid,
    input  logic [SW-1:0] sum_in,
    output logic          out_valid,
    output logic [DW-1:0] out,
    output logic          err,
    output logic [7:0]    count
);

    localparam int unsigned XW = SW + 2;
    localparam int unsigned CW = 8;
    localparam logic [SW-1:0] SUM_MAX = SW'(4 * ((1 << DW) - 1));
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [SW-1:0]        prev_sum_q, prev_sum_d;
    logic [3:0][DW-1:0]   hist_q, hist_d;
    logic [DW-1:0]        out_q, out_d;
    logic                 out_valid_q, out_valid_d;
    logic                 err_q, err_d;
    logic [CW-1:0]        count_q, count_d;

    logic [XW-1:0]        diff_c;
    logic                 diff_neg_c;
    logic                 diff_big_c;
    logic                 sum_big_c;

    // Two's-complement difference; XW bits cover -(2^SW-1) .. 2^SW-1 + 2^DW-1
    assign diff_c     = XW'(sum_in) - XW'(prev_sum_q) + XW'(hist_q[3]);
    assign diff_neg_c = diff_c[XW-1];
    assign diff_big_c = !diff_neg_c && (|diff_c[XW-2:DW]);
    assign sum_big_c  = sum_in > SUM_MAX;

    always_comb begin
        prev_sum_d  = prev_sum_q;
        hist_d      = hist_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        err_d       = err_q;
        count_d     = count_q;
        if (clear) begin
            prev_sum_d = '0;
            hist_d     = '0;
            out_d      = '0;
            err_d      = 1'b0;
            count_d    = '0;
        end else if (in_valid) begin
            out_d       = diff_c[DW-1:0];
            out_valid_d = 1'b1;
            hist_d      = {hist_q[2:0], diff_c[DW-1:0]};
            prev_sum_d  = sum_in;
            if (count_q != CNT_MAX) begin
                count_d = count_q + CW'(1);
            end
            if (diff_neg_c || diff_big_c || sum_big_c) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_sum_q  <= '0;
            hist_q      <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            count_q     <= '0;
        end else begin
            prev_sum_q  <= prev_sum_d;
            hist_q      <= hist_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            count_q     <= count_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign err       = err_q;
    assign count     = count_q;

endmodule
